// File: rtl/fft8_pkg.sv
// Shared types and helpers for the 8-point FFT frame sequencer.
// Index width and point count are fixed by the butterfly datapath.
package fft8_pkg;

   localparam int N_PTS       = 8;
   localparam int IDX_W       = 3;
   localparam int DATA_W_DFLT = 50;
   localparam int HALF_W      = DATA_W_DFLT / 2;

   typedef struct packed {
      logic signed [HALF_W-1:0] re;
      logic signed [HALF_W-1:0] im;
   } cplx_t;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2
   } ctrl_state_e;

   function automatic logic [IDX_W-1:0] bitrev3(input logic [IDX_W-1:0] k);
      return {k[0], k[1], k[2]};
   endfunction

endpackage

// File: rtl/fft8_frame_ctrl.sv
// Frame sequencer for the 8-point radix-2 butterfly datapath: loads 8 samples,
// waits out the multiplier pipeline, then streams the 8 bins out in order.
//
// state | meaning
// LOAD  | accepting samples, writing datapath slot cnt
// WAIT  | pipeline latency countdown, no handshakes
// DRAIN | presenting bin cnt downstream, result slot selected by cnt
module fft8_frame_ctrl
   import fft8_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DFLT,
   parameter int PIPE_LAT = 12,
   parameter int BITREV   = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [DATA_W-1:0] s_data_i,
   input  logic              s_valid_i,
   input  logic              s_last_i,
   output logic              s_ready_o,
   input  logic              abort_i,
   output logic [DATA_W-1:0] bf_signal_o,
   output logic [IDX_W-1:0]  bf_num_o,
   output logic              bf_load_o,
   output logic [IDX_W-1:0]  bf_res_idx_o,
   input  logic [DATA_W-1:0] bf_result_i,
   output logic [DATA_W-1:0] m_data_o,
   output logic [IDX_W-1:0]  m_idx_o,
   output logic              m_valid_o,
   output logic              m_last_o,
   input  logic              m_ready_i,
   output logic              busy_o,
   output logic              err_o,
   output logic              frame_done_o
);

   localparam int               LAT_W    = $clog2(PIPE_LAT + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PTS - 1);
   localparam logic [LAT_W-1:0] LAT_END  = LAT_W'(PIPE_LAT - 1);

   ctrl_state_e      state_q, state_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic [LAT_W-1:0] lat_q, lat_d;
   logic             err_q, err_d;
   logic             done_q, done_d;
   logic             s_acc;
   logic             m_acc;

   assign s_acc = s_valid_i & s_ready_o;
   assign m_acc = m_valid_o & m_ready_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= LOAD;
         cnt_q   <= '0;
         lat_q   <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lat_q   <= lat_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lat_d   = lat_q;
      err_d   = 1'b0;
      done_d  = 1'b0;
      // Abort outranks every handshake; no pulses are generated for the dropped beat.
      if (abort_i) begin
         state_d = LOAD;
         cnt_d   = '0;
         lat_d   = '0;
      end else begin
         case (state_q)
            LOAD: begin
               if (s_acc) begin
                  err_d = s_last_i ^ (cnt_q == LAST_IDX);
                  if (cnt_q == LAST_IDX) begin
                     cnt_d   = '0;
                     lat_d   = '0;
                     state_d = WAIT;
                  end else begin
                     cnt_d = cnt_q + IDX_W'(1);
                  end
               end
            end
            WAIT: begin
               lat_d = lat_q + LAT_W'(1);
               if (lat_q == LAT_END) begin
                  lat_d   = '0;
                  state_d = DRAIN;
               end
            end
            DRAIN: begin
               if (m_acc) begin
                  if (cnt_q == LAST_IDX) begin
                     cnt_d   = '0;
                     done_d  = 1'b1;
                     state_d = LOAD;
                  end else begin
                     cnt_d = cnt_q + IDX_W'(1);
                  end
               end
            end
            default: begin
               state_d = LOAD;
               cnt_d   = '0;
               lat_d   = '0;
            end
         endcase
      end
   end

   always_comb begin
      s_ready_o    = 1'b0;
      bf_load_o    = 1'b0;
      bf_signal_o  = '0;
      bf_num_o     = '0;
      bf_res_idx_o = '0;
      m_valid_o    = 1'b0;
      m_idx_o      = '0;
      m_last_o     = 1'b0;
      m_data_o     = '0;
      case (state_q)
         LOAD: begin
            s_ready_o = ~abort_i;
            bf_num_o  = cnt_q;
            bf_load_o = s_valid_i & ~abort_i;
            if (s_valid_i && !abort_i) begin
               bf_signal_o = s_data_i;
            end
         end
         DRAIN: begin
            m_valid_o    = ~abort_i;
            m_idx_o      = cnt_q;
            m_last_o     = (cnt_q == LAST_IDX) & ~abort_i;
            bf_res_idx_o = (BITREV != 0) ? bitrev3(cnt_q) : cnt_q;
            // Datapath holds still during DRAIN, so the result passes straight through.
            m_data_o     = bf_result_i;
         end
         default: ;
      endcase
      busy_o       = (state_q != LOAD) || (cnt_q != '0);
      err_o        = err_q;
      frame_done_o = done_q;
   end

endmodule

// File: doc/fft8_frame_ctrl.md
Name: fft8_frame_ctrl

Overview:
- Sequencer for the 8-point radix-2 FFT butterfly datapath.
- Accepts a stream of complex samples over a valid/ready handshake and writes them one per cycle into the datapath's sample registers with an index.
- Waits out the datapath's multiplier pipeline latency, then reads the 8 results back in natural frequency order as a valid/ready output stream with last/index tags.
- Sits between the sample source (ADC/front-end FIFO) and the downstream spectrum consumer; owns all frame timing for the butterfly datapath.

Parameters:
- DATA_W, 50, complex sample width {re[DATA_W-1:DATA_W/2], im[DATA_W/2-1:0]}, signed halves.
- N_PTS, 8, points per frame; fixed at 8, index width 3.
- PIPE_LAT, 12, cycles from the last sample write until all datapath outputs are valid and stable.
- BITREV, 1, 1 = read result slot bitrev(k) for output k; 0 = read slot k.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- s_data_i  in  DATA_W  input sample.
- s_valid_i  in  1  input sample valid.
- s_last_i  in  1  input marks frame's last sample.
- s_ready_o  out  1  controller accepts sample.
- abort_i  in  1  synchronous abort of the current frame.
- bf_signal_o  out  DATA_W  sample to datapath.
- bf_num_o  out  3  datapath sample slot index.
- bf_load_o  out  1  datapath sample-register write strobe.
- bf_res_idx_o  out  3  datapath result slot select.
- bf_result_i  in  DATA_W  selected datapath result.
- m_data_o  out  DATA_W  output bin.
- m_idx_o  out  3  output bin number k.
- m_valid_o  out  1  output valid.
- m_last_o  out  1  output is bin 7.
- m_ready_i  in  1  downstream ready.
- busy_o  out  1  state != LOAD or load count != 0.
- err_o  out  1  one-cycle pulse on framing error.
- frame_done_o  out  1  one-cycle pulse when bin 7 is accepted.

Behaviour:
- Reset (async, any state): state=LOAD, cnt=0, lat_cnt=0.
  - All outputs 0 except s_ready_o=1.
  - A frame in progress is discarded; the datapath is not flushed.
- FSM states: LOAD, WAIT, DRAIN.
- LOAD:
  - s_ready_o=1.
  - Accept when s_valid_i&s_ready_o: bf_load_o=1, bf_signal_o=s_data_i, bf_num_o=cnt (combinational, same cycle); cnt++.
  - On accept with cnt==7: cnt<=0, lat_cnt<=0, go to WAIT.
- Framing check (on accept):
  - s_last_i=1 with cnt!=7, or s_last_i=0 with cnt==7 -> err_o pulses next cycle.
  - Framing is by count only; s_last_i never shortens or extends a frame.
- WAIT:
  - s_ready_o=0, bf_load_o=0.
  - lat_cnt++ each cycle; when lat_cnt==PIPE_LAT-1, go to DRAIN.
  - First DRAIN cycle is therefore PIPE_LAT+1 cycles after the last accept edge.
- DRAIN:
  - m_valid_o=1; m_idx_o=cnt; m_last_o=(cnt==7).
  - bf_res_idx_o = BITREV ? bitrev3(cnt) : cnt.
  - m_data_o = bf_result_i, combinational pass-through. The datapath is stable because no loads occur in DRAIN.
  - Advance on m_valid_o&m_ready_i: cnt++.
  - On accept with cnt==7: frame_done_o pulses next cycle, cnt<=0, go to LOAD.
  - m_valid_o, m_idx_o and m_data_o stay stable while m_ready_i=0 (AXI-stream rules).
- Throughput:
  - Minimum frame period = 8 + PIPE_LAT + 8 cycles.
  - No overlap: the next frame's first sample is accepted no earlier than the cycle after frame_done_o's triggering edge.
- abort_i:
  - Sampled in any state; highest priority over handshakes in the same cycle.
  - Next state LOAD, cnt=0, lat_cnt=0.
  - No accept is counted that cycle: s_ready_o and m_valid_o are forced 0 while abort_i=1.
  - No err_o or frame_done_o pulse.
- Simultaneous events:
  - err_o and frame_done_o never coincide; they come from different states.
  - abort_i in the same cycle as the 8th accept is an abort; the beat is dropped.
- Widths: no arithmetic on data; data passes unmodified. Counters are 3-bit and wrap only through the explicit transitions above. lat_cnt width = $clog2(PIPE_LAT+1).

Decomposition:
- Package fft8_pkg:
  - typedef cplx_t (packed struct re/im, DATA_W/2 each).
  - localparam N_PTS=8, IDX_W=3.
  - typedef enum ctrl_state_e {LOAD, WAIT, DRAIN}.
  - function bitrev3.
- No sub-module needed; single always_ff for state/counters plus an always_comb for outputs.
- The bench instantiates it with the butterfly datapath as DUT pair, plus standalone with a behavioural result model.

Test Plan:
- Single frame, PIPE_LAT=12, m_ready_i=1, samples re=1..8, im=0 with s_last_i on beat 8:
  - bf_num_o 0..7 on consecutive cycles.
  - First m_valid_o 13 cycles after the 8th accept.
  - m_idx_o 0..7 with bf_res_idx_o 0,4,2,6,1,5,3,7.
  - m_last_o on idx 7; frame_done_o one pulse; no err_o.
- Backpressure: m_ready_i toggled 1,0,0,1,... during DRAIN -> m_data_o/m_idx_o held while stalled; exactly 8 accepts; s_ready_o=0 until frame_done_o.
- Framing error: s_last_i on beat 5 -> err_o pulse the cycle after beat 5; loading continues to beat 8. Then s_last_i absent on beat 8 of the next frame -> second err_o pulse.
- Abort: abort_i at beat 4 of LOAD -> s_ready_o=0 that cycle. The next 8 accepted beats restart bf_num_o at 0; the results correspond to the new frame only.
- Async reset mid-DRAIN (idx 3): rst_i asserted between clock edges -> m_valid_o=0 and s_ready_o=1 immediately, without waiting for a clock edge. After release the next frame behaves as in scenario 1.
- BITREV=0 with back-to-back frames -> bf_res_idx_o equals m_idx_o. Second frame's first accept occurs on the cycle after frame 1's last DRAIN accept; measured period = 28 cycles.
